// File: rtl/bip_control_unit.sv
// BIP control unit: program counter, decoder and sequencer with branches,
// CALL/RET on a hardware return stack, stall handshake and HALT/FAULT states.
module bip_control_unit #(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned OPCODE_BITS = 5,
  parameter int unsigned PC_BITS     = 11,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               i_instruction,
  input  logic                               i_acc_zero,
  input  logic                               i_stall,
  output logic [PC_BITS-1:0]                 o_prog_address,
  output logic [DATA_BITS-OPCODE_BITS-1:0]   o_operand,
  output logic [1:0]                         o_sel_a,
  output logic                               o_sel_b,
  output logic                               o_write_acc,
  output logic                               o_operation,
  output logic                               o_write_mem,
  output logic                               o_read_mem,
  output logic                               o_done,
  output logic                               o_fault,
  output logic                               o_illegal
);

  localparam int unsigned OPERAND_BITS = DATA_BITS - OPCODE_BITS;
  localparam int unsigned SP_BITS      = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STACK_SLOTS  = 2 ** SP_BITS;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);
  localparam logic [OPCODE_BITS-1:0] OP_JMP  = OPCODE_BITS'(8);
  localparam logic [OPCODE_BITS-1:0] OP_BEZ  = OPCODE_BITS'(9);
  localparam logic [OPCODE_BITS-1:0] OP_BNZ  = OPCODE_BITS'(10);
  localparam logic [OPCODE_BITS-1:0] OP_CALL = OPCODE_BITS'(11);
  localparam logic [OPCODE_BITS-1:0] OP_RET  = OPCODE_BITS'(12);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_e;

  state_e              state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [SP_BITS-1:0]  sp_q, sp_d;
  logic [PC_BITS-1:0]  stack_q [STACK_SLOTS];
  logic [PC_BITS-1:0]  stack_d [STACK_SLOTS];

  logic [OPCODE_BITS-1:0]  opcode;
  logic [OPERAND_BITS-1:0] operand;
  logic [PC_BITS-1:0]      pc_inc;
  logic [PC_BITS-1:0]      target;
  logic [PC_BITS-1:0]      stack_top;
  logic                    active;
  logic                    full;
  logic                    empty;
  logic                    push;

  assign opcode    = i_instruction[DATA_BITS-1 -: OPCODE_BITS];
  assign operand   = i_instruction[OPERAND_BITS-1:0];
  assign pc_inc    = pc_q + PC_BITS'(1);
  assign target    = PC_BITS'(operand);
  assign stack_top = stack_q[sp_q - SP_BITS'(1)];
  assign active    = (state_q == ST_RUN) && !i_stall;
  assign full      = (sp_q == SP_BITS'(STACK_DEPTH));
  assign empty     = (sp_q == '0);

  assign o_prog_address = pc_q;
  assign o_operand      = operand;
  assign o_done         = (state_q == ST_HALT);
  assign o_fault        = (state_q == ST_FAULT);
  assign o_illegal      = (state_q == ST_RUN) && (opcode > OP_RET);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  // Return-stack storage carries no reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  // Sequencer: next pc, stack pointer and FSM state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    if (active) begin
      pc_d = pc_inc;
      case (opcode)
        OP_HLT: begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
        OP_JMP: pc_d = target;
        OP_BEZ: if (i_acc_zero) pc_d = target;
        OP_BNZ: if (!i_acc_zero) pc_d = target;
        OP_CALL: begin
          if (full) begin
            state_d = ST_FAULT;
            pc_d    = pc_q;
          end else begin
            pc_d = target;
            sp_d = sp_q + SP_BITS'(1);
            push = 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            state_d = ST_FAULT;
            pc_d    = pc_q;
          end else begin
            pc_d = stack_top;
            sp_d = sp_q - SP_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stack_d = stack_q;
    if (push) stack_d[sp_q] = pc_inc;
  end

  // Datapath control decode; everything idles unless running unstalled.
  always_comb begin
    o_sel_a     = 2'b00;
    o_sel_b     = 1'b0;
    o_write_acc = 1'b0;
    o_operation = 1'b0;
    o_write_mem = 1'b0;
    o_read_mem  = 1'b0;
    if (active) begin
      case (opcode)
        OP_STO: o_write_mem = 1'b1;
        OP_LD: begin
          o_read_mem  = 1'b1;
          o_write_acc = 1'b1;
        end
        OP_LDI: begin
          o_write_acc = 1'b1;
          o_sel_a     = 2'b01;
        end
        OP_ADD, OP_SUB: begin
          o_read_mem  = 1'b1;
          o_write_acc = 1'b1;
          o_sel_a     = 2'b10;
          o_operation = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          o_write_acc = 1'b1;
          o_sel_a     = 2'b10;
          o_sel_b     = 1'b1;
          o_operation = (opcode == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: decode, branches, call/return stack,
// stall, halt/fault and reset recovery, checked with immediate assertions.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_instruction;
  logic        i_acc_zero;
  logic        i_stall;
  logic [10:0] o_prog_address;
  logic [10:0] o_operand;
  logic [1:0]  o_sel_a;
  logic        o_sel_b, o_write_acc, o_operation, o_write_mem, o_read_mem;
  logic        o_done, o_fault, o_illegal;
  logic [6:0]  ctl;

  int total = 0;
  int bad   = 0;

  bip_control_unit #(.DATA_BITS(16), .OPCODE_BITS(5), .PC_BITS(11), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_instruction(i_instruction), .i_acc_zero(i_acc_zero),
    .i_stall(i_stall), .o_prog_address(o_prog_address), .o_operand(o_operand),
    .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_write_acc(o_write_acc),
    .o_operation(o_operation), .o_write_mem(o_write_mem), .o_read_mem(o_read_mem),
    .o_done(o_done), .o_fault(o_fault), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  // {sel_a[1:0], sel_b, write_acc, operation, write_mem, read_mem}
  assign ctl = {o_sel_a, o_sel_b, o_write_acc, o_operation, o_write_mem, o_read_mem};

  localparam logic [6:0] C_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] C_LDI  = 7'b01_0_1_0_0_0;
  localparam logic [6:0] C_ADDI = 7'b10_1_1_0_0_0;
  localparam logic [6:0] C_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] C_LD   = 7'b00_0_1_0_0_1;
  localparam logic [6:0] C_SUB  = 7'b10_0_1_1_0_1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic zero, input logic stall);
    i_instruction = instr;
    i_acc_zero    = zero;
    i_stall       = stall;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    i_instruction = '0;
    i_acc_zero = 1'b0;
    i_stall = 1'b0;
    tick();
    tick();
    chk("reset_pc", 32'(o_prog_address), 32'h0);
    chk("reset_done", 32'(o_done), 32'h0);
    chk("reset_fault", 32'(o_fault), 32'h0);
    rst = 1'b1;

    // LDI 5, ADDI 3, STO 7, HLT
    drive(ins(5'h03, 11'd5), 1'b0, 1'b0);
    chk("ldi_ctl", 32'(ctl), 32'(C_LDI));
    chk("ldi_operand", 32'(o_operand), 32'd5);
    tick();
    chk("pc_1", 32'(o_prog_address), 32'd1);
    drive(ins(5'h05, 11'd3), 1'b0, 1'b0);
    chk("addi_ctl", 32'(ctl), 32'(C_ADDI));
    tick();
    drive(ins(5'h01, 11'd7), 1'b0, 1'b0);
    chk("sto_ctl", 32'(ctl), 32'(C_STO));
    tick();
    chk("pc_3", 32'(o_prog_address), 32'd3);
    drive(ins(5'h00, 11'd0), 1'b0, 1'b0);
    chk("hlt_ctl", 32'(ctl), 32'(C_NONE));
    chk("hlt_done_before", 32'(o_done), 32'h0);
    tick();
    chk("halt_done", 32'(o_done), 32'h1);
    chk("halt_pc", 32'(o_prog_address), 32'd3);
    drive(ins(5'h03, 11'd9), 1'b0, 1'b0);
    chk("halt_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("halt_pc_hold", 32'(o_prog_address), 32'd3);
    chk("halt_done_hold", 32'(o_done), 32'h1);
    do_reset();
    chk("halt_rst_pc", 32'(o_prog_address), 32'd0);
    chk("halt_rst_done", 32'(o_done), 32'h0);

    // Conditional branches
    drive(ins(5'h09, 11'h020), 1'b1, 1'b0);
    tick();
    chk("bez_taken", 32'(o_prog_address), 32'h20);
    drive(ins(5'h09, 11'h040), 1'b0, 1'b0);
    tick();
    chk("bez_not_taken", 32'(o_prog_address), 32'h21);
    drive(ins(5'h0A, 11'h040), 1'b0, 1'b0);
    tick();
    chk("bnz_taken", 32'(o_prog_address), 32'h40);
    drive(ins(5'h0A, 11'h010), 1'b1, 1'b0);
    tick();
    chk("bnz_not_taken", 32'(o_prog_address), 32'h41);
    drive(ins(5'h06, 11'd2), 1'b0, 1'b0);
    chk("sub_ctl", 32'(ctl), 32'(C_SUB));

    // CALL / RET, then overflow the stack
    drive(ins(5'h08, 11'h010), 1'b0, 1'b0);
    tick();
    chk("jmp", 32'(o_prog_address), 32'h10);
    drive(ins(5'h0B, 11'h100), 1'b0, 1'b0);
    tick();
    chk("call", 32'(o_prog_address), 32'h100);
    drive(ins(5'h0C, 11'h000), 1'b0, 1'b0);
    tick();
    chk("ret", 32'(o_prog_address), 32'h11);
    for (int i = 0; i < 4; i++) begin
      drive(ins(5'h0B, 11'(32'h200 + 32'h100 * i)), 1'b0, 1'b0);
      tick();
    end
    chk("nest_pc", 32'(o_prog_address), 32'h500);
    chk("nest_no_fault", 32'(o_fault), 32'h0);
    drive(ins(5'h0B, 11'h600), 1'b0, 1'b0);
    tick();
    chk("overflow_fault", 32'(o_fault), 32'h1);
    chk("overflow_pc", 32'(o_prog_address), 32'h500);
    drive(ins(5'h03, 11'd1), 1'b0, 1'b0);
    chk("fault_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("fault_pc_hold", 32'(o_prog_address), 32'h500);
    do_reset();
    chk("fault_rst_pc", 32'(o_prog_address), 32'h0);
    chk("fault_rst_flag", 32'(o_fault), 32'h0);

    // RET on empty stack
    drive(ins(5'h0C, 11'h000), 1'b0, 1'b0);
    tick();
    chk("underflow_fault", 32'(o_fault), 32'h1);
    chk("underflow_pc", 32'(o_prog_address), 32'h0);
    drive(ins(5'h02, 11'd4), 1'b0, 1'b0);
    chk("underflow_ctl", 32'(ctl), 32'(C_NONE));
    do_reset();
    chk("uf_rst_fault", 32'(o_fault), 32'h0);
    chk("uf_rst_ld_ctl", 32'(ctl), 32'(C_LD));
    tick();
    chk("uf_rst_run", 32'(o_prog_address), 32'h1);

    // Stall during STO
    drive(ins(5'h01, 11'd9), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ctl", 32'(ctl), 32'(C_NONE));
      tick();
    end
    chk("stall_pc", 32'(o_prog_address), 32'h1);
    drive(ins(5'h01, 11'd9), 1'b0, 1'b0);
    chk("unstall_ctl", 32'(ctl), 32'(C_STO));
    tick();
    chk("unstall_pc", 32'(o_prog_address), 32'h2);
    drive(ins(5'h02, 11'd9), 1'b0, 1'b0);
    chk("after_sto_wm", 32'(o_write_mem), 32'h0);

    // Stalled CALL leaves the stack untouched; RET then underflows
    drive(ins(5'h0B, 11'h300), 1'b0, 1'b1);
    tick();
    chk("stall_call_pc", 32'(o_prog_address), 32'h2);
    drive(ins(5'h0C, 11'h000), 1'b0, 1'b0);
    tick();
    chk("stall_call_sp", 32'(o_fault), 32'h1);
    do_reset();

    // PC wrap and illegal opcode
    drive(ins(5'h08, 11'h7FF), 1'b0, 1'b0);
    chk("jmp_not_illegal", 32'(o_illegal), 32'h0);
    tick();
    chk("pc_max", 32'(o_prog_address), 32'h7FF);
    drive(ins(5'h03, 11'd1), 1'b0, 1'b0);
    tick();
    chk("pc_wrap", 32'(o_prog_address), 32'h0);
    drive(ins(5'h1F, 11'h123), 1'b0, 1'b0);
    chk("illegal_flag", 32'(o_illegal), 32'h1);
    chk("illegal_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("illegal_pc", 32'(o_prog_address), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
